boron_xor_layer_pipe: RTL

- Parametrised, pipelined successor of the BORON word-mixing (XOR diffusion) layer.
- Applies the forward layer (encrypt) or its inverse (decrypt) to a 4-word block, selected per transaction.
- Carries data through a stallable valid/ready pipeline of configurable depth.
- Sits between the S-box/permutation stage and the round-key add in the round datapath.

---
 rtl/boron_xor_layer_pipe.sv | 112 +++++++++++
 1 files changed

// File: rtl/boron_xor_layer_pipe.sv
// BORON XOR diffusion layer (forward or inverse per block) behind a stallable
// valid/ready pipeline; mixing happens before stage 0, later stages only carry.
module boron_xor_layer_pipe #(
    parameter int unsigned WORD_W     = 16,
    parameter int unsigned PIPE_DEPTH = 2,
    parameter int unsigned CNT_W      = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*WORD_W-1:0] in_data,
    input  logic                in_inv,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*WORD_W-1:0] out_data,
    output logic                out_inv,
    output logic [CNT_W-1:0]    done_cnt
);
    localparam int unsigned BlkW = 4 * WORD_W;
    localparam int          Last = int'(PIPE_DEPTH) - 1;

    if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_depth
        $error("boron_xor_layer_pipe: PIPE_DEPTH must be in 1..4");
    end

    logic [WORD_W-1:0] w0, w1, w2, w3;
    logic [BlkW-1:0]   mix_data;

    assign {w3, w2, w1, w0} = in_data;

    always_comb begin
        if (in_inv) begin
            mix_data = {w2 ^ w3, w2 ^ w1 ^ w0, w3 ^ w2 ^ w1, w1 ^ w0};
        end else begin
            mix_data = {w3 ^ w2 ^ w0, w2 ^ w0, w3 ^ w1, w3 ^ w1 ^ w0};
        end
    end

    logic [PIPE_DEPTH-1:0] valid_q;
    logic [PIPE_DEPTH-1:0] inv_q;
    logic [BlkW-1:0]       data_q [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0] load;
    logic [PIPE_DEPTH-1:0] src_valid;
    logic [PIPE_DEPTH-1:0] src_inv;
    logic [BlkW-1:0]       src_data [PIPE_DEPTH];
    logic [CNT_W-1:0]      done_cnt_q, done_cnt_d;
    logic                  out_fire;

    // A stage may load unless it and every stage after it are full while the
    // output is stalled; this is the unrolled form of the load chain.
    always_comb begin : p_load
        logic full_below;
        full_below = 1'b1;
        load       = '0;
        for (int k = Last; k >= 0; k--) begin
            full_below = full_below & valid_q[k];
            load[k]    = out_ready | ~full_below;
        end
    end

    for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_src
        if (k == 0) begin : g_head
            assign src_valid[k] = in_valid;
            assign src_inv[k]   = in_inv;
            assign src_data[k]  = mix_data;
        end else begin : g_tail
            assign src_valid[k] = valid_q[k-1];
            assign src_inv[k]   = inv_q[k-1];
            assign src_data[k]  = data_q[k-1];
        end
    end

    assign out_fire = valid_q[Last] & out_ready;

    always_comb begin
        done_cnt_d = done_cnt_q;
        if (out_fire) begin
            done_cnt_d = done_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            inv_q      <= '0;
            done_cnt_q <= '0;
            for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
                data_q[k] <= '0;
            end
        end else begin
            done_cnt_q <= done_cnt_d;
            for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
                if (load[k]) begin
                    valid_q[k] <= src_valid[k];
                    // Payload only moves with a real block so idle outputs stay quiet.
                    if (src_valid[k]) begin
                        data_q[k] <= src_data[k];
                        inv_q[k]  <= src_inv[k];
                    end
                end
            end
        end
    end

    assign in_ready  = load[0];
    assign out_valid = valid_q[Last];
    assign out_data  = data_q[Last];
    assign out_inv   = inv_q[Last];
    assign done_cnt  = done_cnt_q;

endmodule
